decode_stage_pipe: RTL and testbench

//  Registered, parametrised RV32I/RV64I decode stage between the fetch skid buffer and the rename skid buffer.

---
 rtl/decode_stage_pipe.sv | 166 ++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered RV32I/RV64I decode with a main+skid output buffer.
// Ports: clk, rst_n (async, active-low), i_flush kills buffered entries;
//   fetch side i_instr/i_pc/i_valid -> o_ready; rename side o_valid/i_ready plus
//   decoded payload o_pc, o_rs1/o_rs2/o_rd, o_funct3, o_funct7b5, o_immediate,
//   o_alu_op, o_alu_src, o_branch, o_jump, o_pc_rel, o_fu_type, o_mem_read,
//   o_mem_write, o_reg_write, o_illegal.
module decode_stage_pipe #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic [ILEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [2:0]      o_funct3,
  output logic            o_funct7b5,
  output logic [XLEN-1:0] o_immediate,
  output logic [1:0]      o_alu_op,
  output logic            o_alu_src,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_pc_rel,
  output logic            o_fu_type,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_reg_write,
  output logic            o_illegal
);
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] imm;
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic            pc_rel;
    logic            fu_type;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            illegal;
  } entry_t;
  entry_t             dec, main_q, main_d, skid_q, skid_d;
  logic               main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic signed [31:0] imm32;
  logic               wr;
  logic               acc, xfer;
  always_comb begin
    dec          = '0;
    imm32        = '0;
    wr           = 1'b0;
    dec.pc       = i_pc;
    dec.rs1      = i_instr[19:15];
    dec.rs2      = i_instr[24:20];
    dec.rd       = i_instr[11:7];
    dec.funct3   = i_instr[14:12];
    dec.funct7b5 = i_instr[30];
    if (i_instr[1:0] != 2'b11) dec.illegal = 1'b1;
    else begin
      case (i_instr[6:2])
        OP_LUI:    begin imm32 = {i_instr[31:12], 12'b0}; dec.alu_src = 1'b1; wr = 1'b1; end
        OP_AUIPC:  begin imm32 = {i_instr[31:12], 12'b0}; dec.alu_src = 1'b1; dec.pc_rel = 1'b1; wr = 1'b1; end
        OP_JAL:    begin
          imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
          dec.branch = 1'b1; dec.jump = 1'b1; dec.pc_rel = 1'b1; wr = 1'b1;
        end
        OP_JALR:   begin
          imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
          dec.branch = 1'b1; dec.jump = 1'b1; dec.alu_src = 1'b1; wr = 1'b1;
        end
        OP_BRANCH: begin
          imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
          dec.branch = 1'b1; dec.alu_op = 2'b01;
        end
        OP_LOAD:   begin
          imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
          dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.fu_type = 1'b1; wr = 1'b1;
        end
        OP_STORE:  begin
          imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
          dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.fu_type = 1'b1;
        end
        OP_OPIMM:  begin imm32 = {{20{i_instr[31]}}, i_instr[31:20]}; dec.alu_src = 1'b1; dec.alu_op = 2'b11; wr = 1'b1; end
        OP_OP:     begin dec.alu_op = 2'b10; wr = 1'b1; end
        default:   dec.illegal = 1'b1;
      endcase
    end
    dec.imm       = XLEN'(imm32);
    dec.reg_write = wr && (i_instr[11:7] != 5'd0);
  end
  assign acc  = i_valid && !skid_v_q;
  assign xfer = main_v_q && i_ready;
  // Skid can only be full while o_ready is low, so an accept never races a skid drain.
  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (i_flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || xfer) begin
      main_v_d = acc || skid_v_q;
      main_d   = acc ? dec : skid_q;
      skid_v_d = 1'b0;
    end else if (acc) begin
      skid_v_d = 1'b1;
      skid_d   = dec;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end
  assign o_ready     = !skid_v_q;
  assign o_valid     = main_v_q;
  assign o_pc        = main_q.pc;
  assign o_rs1       = main_q.rs1;
  assign o_rs2       = main_q.rs2;
  assign o_rd        = main_q.rd;
  assign o_funct3    = main_q.funct3;
  assign o_funct7b5  = main_q.funct7b5;
  assign o_immediate = main_q.imm;
  assign o_alu_op    = main_q.alu_op;
  assign o_alu_src   = main_q.alu_src;
  assign o_branch    = main_q.branch;
  assign o_jump      = main_q.jump;
  assign o_pc_rel    = main_q.pc_rel;
  assign o_fu_type   = main_q.fu_type;
  assign o_mem_read  = main_q.mem_read;
  assign o_mem_write = main_q.mem_write;
  assign o_reg_write = main_q.reg_write;
  assign o_illegal   = main_q.illegal;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed checks of decode_stage_pipe at XLEN=32 and XLEN=64.
module tb_decode_stage_pipe;
  logic        clk = 1'b0;
  logic        rst_n, i_flush, i_valid, i_ready;
  logic [31:0] i_instr, i_pc;
  logic        o_ready, o_valid, o_funct7b5, o_alu_src, o_branch, o_jump, o_pc_rel;
  logic        o_fu_type, o_mem_read, o_mem_write, o_reg_write, o_illegal;
  logic [31:0] o_pc, o_immediate;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [2:0]  o_funct3;
  logic [1:0]  o_alu_op;
  logic        w_ready, w_valid, w_funct7b5, w_alu_src, w_branch, w_jump, w_pc_rel;
  logic        w_fu_type, w_mem_read, w_mem_write, w_reg_write, w_illegal;
  logic [63:0] w_pc, w_immediate;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [2:0]  w_funct3;
  logic [1:0]  w_alu_op;
  logic [9:0]  ctl;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    logic [31:0] ins;
    logic [63:0] imm;
    logic [9:0]  ctl;
    logic        ill;
  } vec_t;
  vec_t vecs[11];
  always #5 clk = ~clk;
  assign ctl = {o_alu_op, o_alu_src, o_branch, o_jump, o_pc_rel, o_fu_type, o_mem_read, o_mem_write, o_reg_write};
  decode_stage_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_instr(i_instr), .i_pc(i_pc),
    .i_valid(i_valid), .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_funct3(o_funct3),
    .o_funct7b5(o_funct7b5), .o_immediate(o_immediate), .o_alu_op(o_alu_op),
    .o_alu_src(o_alu_src), .o_branch(o_branch), .o_jump(o_jump), .o_pc_rel(o_pc_rel),
    .o_fu_type(o_fu_type), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_reg_write(o_reg_write), .o_illegal(o_illegal)
  );
  decode_stage_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_instr(i_instr), .i_pc({32'h0, i_pc}),
    .i_valid(i_valid), .o_ready(w_ready), .o_valid(w_valid), .i_ready(i_ready),
    .o_pc(w_pc), .o_rs1(w_rs1), .o_rs2(w_rs2), .o_rd(w_rd), .o_funct3(w_funct3),
    .o_funct7b5(w_funct7b5), .o_immediate(w_immediate), .o_alu_op(w_alu_op),
    .o_alu_src(w_alu_src), .o_branch(w_branch), .o_jump(w_jump), .o_pc_rel(w_pc_rel),
    .o_fu_type(w_fu_type), .o_mem_read(w_mem_read), .o_mem_write(w_mem_write),
    .o_reg_write(w_reg_write), .o_illegal(w_illegal)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    i_instr = ins;
    i_pc    = pc;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask
  initial begin
    vecs[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 10'b11_1_0_0_0_0_0_0_1, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 10'b01_0_1_0_0_0_0_0_0, 1'b0};
    vecs[2]  = '{32'h0020A423, 64'h8,                10'b00_1_0_0_0_1_0_1_0, 1'b0};
    vecs[3]  = '{32'h001000EF, 64'h800,              10'b00_0_1_1_1_0_0_0_1, 1'b0};
    vecs[4]  = '{32'h123452B7, 64'h12345000,         10'b00_1_0_0_0_0_0_0_1, 1'b0};
    vecs[5]  = '{32'h00001097, 64'h1000,             10'b00_1_0_0_1_0_0_0_1, 1'b0};
    vecs[6]  = '{32'hFFC100E7, 64'hFFFFFFFFFFFFFFFC, 10'b00_1_1_1_0_0_0_0_1, 1'b0};
    vecs[7]  = '{32'h01012283, 64'h10,               10'b00_1_0_0_0_1_1_0_1, 1'b0};
    vecs[8]  = '{32'h00208033, 64'h0,                10'b10_0_0_0_0_0_0_0_0, 1'b0};
    vecs[9]  = '{32'h0000007F, 64'h0,                10'b00_0_0_0_0_0_0_0_0, 1'b1};
    vecs[10] = '{32'hFFF00091, 64'h0,                10'b00_0_0_0_0_0_0_0_0, 1'b1};
    rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_instr = '0; i_pc = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_imm", o_immediate, 0);
    rst_n   = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      push(vecs[k].ins, 32'h100 + 32'(k) * 4);
      check($sformatf("valid[%0d]", k), o_valid, 1);
      check($sformatf("pc[%0d]", k), o_pc, 32'h100 + 32'(k) * 4);
      check($sformatf("imm32[%0d]", k), o_immediate, vecs[k].imm[31:0]);
      check($sformatf("imm64[%0d]", k), w_immediate, vecs[k].imm);
      check($sformatf("ctl[%0d]", k), ctl, vecs[k].ctl);
      check($sformatf("illegal[%0d]", k), o_illegal, vecs[k].ill);
    end
    @(negedge clk);
    check("drain_valid", o_valid, 0);
    push(32'h402081B3, 32'h180);
    check("sub_rs1", o_rs1, 1);
    check("sub_rs2", o_rs2, 2);
    check("sub_rd", o_rd, 3);
    check("sub_f3", o_funct3, 0);
    check("sub_f7b5", o_funct7b5, 1);
    check("sub_ctl", ctl, 10'b10_0_0_0_0_0_0_0_1);
    @(negedge clk);
    i_ready = 1'b0;
    push(32'h002081B3, 32'h200);
    check("bp_a_valid", o_valid, 1);
    check("bp_a_pc", o_pc, 32'h200);
    check("bp_a_ready", o_ready, 1);
    push(32'h002081B3, 32'h204);
    check("bp_b_ready", o_ready, 0);
    check("bp_b_pc", o_pc, 32'h200);
    i_pc = 32'h208; i_valid = 1'b1;
    @(negedge clk);
    check("bp_hold_pc", o_pc, 32'h200);
    check("bp_hold_ready", o_ready, 0);
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_out_a", o_pc, 32'h204);
    check("bp_out_a_ready", o_ready, 1);
    @(negedge clk);
    i_valid = 1'b0;
    check("bp_out_b", o_pc, 32'h208);
    check("bp_out_b_valid", o_valid, 1);
    @(negedge clk);
    check("bp_out_c_empty", o_valid, 0);
    i_ready = 1'b0;
    push(32'h002081B3, 32'h300);
    push(32'h002081B3, 32'h304);
    check("fl_full_ready", o_ready, 0);
    i_flush = 1'b1; i_pc = 32'h308; i_valid = 1'b1;
    @(negedge clk);
    i_flush = 1'b0; i_valid = 1'b0;
    check("fl_valid", o_valid, 0);
    check("fl_ready", o_ready, 1);
    i_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("fl_no_ghost", o_valid, 0);
    i_ready = 1'b0;
    push(32'h002081B3, 32'h400);
    check("fl2_valid", o_valid, 1);
    i_flush = 1'b1; i_pc = 32'h404; i_valid = 1'b1;
    @(negedge clk);
    i_flush = 1'b0; i_valid = 1'b0;
    check("fl2_cleared", o_valid, 0);
    @(negedge clk);
    check("fl2_dropped", o_valid, 0);
    push(32'hFFF00093, 32'h500);
    push(32'hFFF00093, 32'h504);
    check("rst2_pre_ready", o_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_valid", o_valid, 0);
    check("rst2_ready", o_ready, 1);
    check("rst2_imm", o_immediate, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
